reg_bank_ctrl: RTL and testbench



---
 rtl/reg_bank_ctrl.sv | 131 +++++++++++++
 tb/tb_reg_bank_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: command-driven initiator for the A/B/C register bank with registered outputs.
// Optional write-verify readback enabled by defining REG_BANK_CTRL_VERIFY_EN.
module reg_bank_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_sel,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [7:0]  bank_data_a,
  output logic [7:0]  bank_data_b,
  output logic [15:0] bank_data_c,
  output logic        ld_a,
  output logic        ld_b,
  output logic        ld_c,
  output logic [1:0]  output_sel,
  input  logic [15:0] bank_data_out
);
  typedef enum logic [2:0] {IDLE, WR, RD_SEL, RD_CAP, RESP} state_t;
  state_t      state_q;
  logic [1:0]  sel_q, output_sel_q;
  logic [15:0] data_q, rsp_data_q, bank_data_c_q, exp_w, cap_w;
  logic [7:0]  bank_data_a_q, bank_data_b_q;
  logic        cmd_ready_q, rsp_valid_q, rsp_err_q, ld_a_q, ld_b_q, ld_c_q;
`ifdef REG_BANK_CTRL_VERIFY_EN
  logic        wr_q;
`endif
  // A/B are 8-bit registers, so only C carries a meaningful upper byte; target 11 always reads as zero
  assign exp_w = sel_q[1] ? data_q : {8'h00, data_q[7:0]};
  assign cap_w = (sel_q == 2'b11) ? 16'h0000 : sel_q[1] ? bank_data_out : {8'h00, bank_data_out[7:0]};
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      sel_q         <= 2'b11;
      data_q        <= 16'h0000;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= 16'h0000;
      ld_a_q        <= 1'b0;
      ld_b_q        <= 1'b0;
      ld_c_q        <= 1'b0;
      bank_data_a_q <= 8'h00;
      bank_data_b_q <= 8'h00;
      bank_data_c_q <= 16'h0000;
      output_sel_q  <= 2'b11;
`ifdef REG_BANK_CTRL_VERIFY_EN
      wr_q          <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          sel_q       <= cmd_sel;
          data_q      <= cmd_data;
          cmd_ready_q <= 1'b0;
`ifdef REG_BANK_CTRL_VERIFY_EN
          wr_q        <= cmd_wr;
`endif
          if (cmd_wr) begin
            state_q <= WR;
            ld_a_q  <= cmd_sel == 2'b00;
            ld_b_q  <= cmd_sel == 2'b01;
            ld_c_q  <= cmd_sel == 2'b10;
            if (cmd_sel == 2'b00) bank_data_a_q <= cmd_data[7:0];
            if (cmd_sel == 2'b01) bank_data_b_q <= cmd_data[7:0];
            if (cmd_sel == 2'b10) bank_data_c_q <= cmd_data;
          end else begin
            state_q      <= RD_SEL;
            output_sel_q <= cmd_sel;
          end
        end
        WR: begin
          ld_a_q <= 1'b0;
          ld_b_q <= 1'b0;
          ld_c_q <= 1'b0;
`ifdef REG_BANK_CTRL_VERIFY_EN
          if (sel_q != 2'b11) begin
            state_q      <= RD_SEL;
            output_sel_q <= sel_q;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= exp_w;
            rsp_err_q   <= 1'b1;
          end
`else
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= exp_w;
          rsp_err_q   <= sel_q == 2'b11;
`endif
        end
        RD_SEL: state_q <= RD_CAP;
        RD_CAP: begin
          state_q      <= RESP;
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= cap_w;
          output_sel_q <= 2'b11;
`ifdef REG_BANK_CTRL_VERIFY_EN
          rsp_err_q    <= wr_q && (cap_w != exp_w);
`else
          rsp_err_q    <= 1'b0;
`endif
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign bank_data_a = bank_data_a_q;
  assign bank_data_b = bank_data_b_q;
  assign bank_data_c = bank_data_c_q;
  assign ld_a        = ld_a_q;
  assign ld_b        = ld_b_q;
  assign ld_c        = ld_c_q;
  assign output_sel  = output_sel_q;
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb_reg_bank_ctrl: directed bench for reg_bank_ctrl against a behavioural A/B/C bank model.
module tb_reg_bank_ctrl;
  logic        Clock = 1'b0, Reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  cmd_sel = 2'b00;
  logic [15:0] cmd_data = 16'h0000;
  logic        cmd_ready, rsp_valid, rsp_err, ld_a, ld_b, ld_c;
  logic [15:0] rsp_data, bank_data_c;
  logic [7:0]  bank_data_a, bank_data_b;
  logic [1:0]  output_sel;
  logic [15:0] bank_data_out = 16'h0000;
  logic [7:0]  ra = 8'h00, rb = 8'h00;
  logic [15:0] rc = 16'h0000;
  logic        force_zero = 1'b0;
  int checks = 0, failures = 0;
`ifdef REG_BANK_CTRL_VERIFY_EN
  localparam int LW = 4;
`else
  localparam int LW = 2;
`endif

  reg_bank_ctrl dut (
    .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_sel(cmd_sel), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bank_data_a(bank_data_a), .bank_data_b(bank_data_b), .bank_data_c(bank_data_c),
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .output_sel(output_sel),
    .bank_data_out(bank_data_out)
  );

  always #5 Clock = ~Clock;

  // bank: loads on ld_x, mux output registered one edge after output_sel
  always @(posedge Clock) begin
    if (ld_a) ra <= bank_data_a;
    if (ld_b) rb <= bank_data_b;
    if (ld_c) rc <= bank_data_c;
    bank_data_out <= force_zero ? 16'h0000 :
                     output_sel == 2'b00 ? {8'h00, ra} :
                     output_sel == 2'b01 ? {8'h00, rb} :
                     output_sel == 2'b10 ? rc : 16'h0000;
  end

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [1:0] sel, input logic [15:0] d,
                        input logic [2:0] eld, input logic [1:0] eosel, input int lat,
                        input logic chkd, input logic [15:0] edata, input logic eerr);
    @(negedge Clock);
    chk("accept_ready", {15'd0, cmd_ready}, 16'd1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_sel = sel; cmd_data = d;
    @(negedge Clock);
    cmd_valid = 1'b0;
    chk("c1_ld", {13'd0, ld_c, ld_b, ld_a}, {13'd0, eld});
    chk("c1_osel", {14'd0, output_sel}, {14'd0, eosel});
    chk("c1_ready", {15'd0, cmd_ready}, 16'd0);
    chk("c1_valid", {15'd0, rsp_valid}, 16'd0);
    for (int i = 2; i <= lat; i++) begin
      @(negedge Clock);
      if (i == 2) chk("c2_ld", {13'd0, ld_c, ld_b, ld_a}, 16'd0);
      if (i < lat) chk("early_valid", {15'd0, rsp_valid}, 16'd0);
    end
    chk("rsp_valid", {15'd0, rsp_valid}, 16'd1);
    if (chkd) chk("rsp_data", rsp_data, edata);
    chk("rsp_err", {15'd0, rsp_err}, {15'd0, eerr});
    rsp_ready = 1'b1;
    @(negedge Clock);
    rsp_ready = 1'b0;
    chk("post_valid", {15'd0, rsp_valid}, 16'd0);
    chk("post_ready", {15'd0, cmd_ready}, 16'd1);
    chk("post_osel", {14'd0, output_sel}, 16'd3);
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_osel", {14'd0, output_sel}, 16'd3);
    chk("rst_ld", {13'd0, ld_c, ld_b, ld_a}, 16'd0);
    chk("rst_valid", {15'd0, rsp_valid}, 16'd0);
    chk("rst_data", rsp_data, 16'h0000);
    chk("rst_bda", {8'd0, bank_data_a}, 16'h0000);
    Reset = 1'b0;
    do_cmd(1'b1, 2'b00, 16'h00A5, 3'b001, 2'b11, LW, 1'b1, 16'h00A5, 1'b0);
    chk("bda_hold", {8'd0, bank_data_a}, 16'h00A5);
    do_cmd(1'b0, 2'b00, 16'h0000, 3'b000, 2'b00, 3, 1'b1, 16'h00A5, 1'b0);
    do_cmd(1'b1, 2'b10, 16'hBEEF, 3'b100, 2'b11, LW, 1'b1, 16'hBEEF, 1'b0);
    chk("bdc_hold", bank_data_c, 16'hBEEF);
    do_cmd(1'b0, 2'b10, 16'h0000, 3'b000, 2'b10, 3, 1'b1, 16'hBEEF, 1'b0);
    do_cmd(1'b1, 2'b11, 16'h1234, 3'b000, 2'b11, 2, 1'b0, 16'h0000, 1'b1);
    do_cmd(1'b0, 2'b11, 16'h0000, 3'b000, 2'b11, 3, 1'b1, 16'h0000, 1'b0);
    do_cmd(1'b1, 2'b01, 16'hFF3C, 3'b010, 2'b11, LW, 1'b1, 16'h003C, 1'b0);
    do_cmd(1'b0, 2'b01, 16'h0000, 3'b000, 2'b01, 3, 1'b1, 16'h003C, 1'b0);
    // backpressure: response must hold while a stray command is offered
    @(negedge Clock);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_sel = 2'b01; cmd_data = 16'h0077;
    @(negedge Clock);
    cmd_valid = 1'b0;
    repeat (LW - 1) @(negedge Clock);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_sel = 2'b10;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {15'd0, rsp_valid}, 16'd1);
      chk("hold_data", rsp_data, 16'h0077);
      chk("hold_ready", {15'd0, cmd_ready}, 16'd0);
      @(negedge Clock);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge Clock);
    rsp_ready = 1'b0;
    chk("hold_done_valid", {15'd0, rsp_valid}, 16'd0);
    chk("hold_done_ready", {15'd0, cmd_ready}, 16'd1);
    @(negedge Clock);
    chk("stray_ignored_osel", {14'd0, output_sel}, 16'd3);
    chk("stray_ignored_ready", {15'd0, cmd_ready}, 16'd1);
    // reset during RD_CAP discards the read
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_sel = 2'b10; cmd_data = 16'h0000;
    @(negedge Clock);
    cmd_valid = 1'b0;
    @(negedge Clock);
    chk("rdcap_osel", {14'd0, output_sel}, 16'd2);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("mid_rst_valid", {15'd0, rsp_valid}, 16'd0);
    chk("mid_rst_osel", {14'd0, output_sel}, 16'd3);
    chk("mid_rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("mid_rst_data", rsp_data, 16'h0000);
    chk("mid_rst_bdc", bank_data_c, 16'h0000);
    repeat (3) begin
      @(negedge Clock);
      chk("no_rsp_after_rst", {15'd0, rsp_valid}, 16'd0);
    end
    do_cmd(1'b0, 2'b10, 16'h0000, 3'b000, 2'b10, 3, 1'b1, 16'hBEEF, 1'b0);
`ifdef REG_BANK_CTRL_VERIFY_EN
    force_zero = 1'b1;
    do_cmd(1'b1, 2'b01, 16'h003C, 3'b010, 2'b11, 4, 1'b1, 16'h0000, 1'b1);
    force_zero = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
